mem_bank_sequencer: RTL and testbench

- Request front-end for the 7-bank unified data memory.
- Accepts single-word load/store requests from the pipeline memory stage over a valid/ready handshake and buffers them in order.
- Decodes each address into a bank index and an offset, and drives the memory's packed per-bank write enable, address and write-data buses.
- Captures the combinational read data into a registered response with its own valid/ready handshake.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_req_fifo.sv | 48 ++++
 rtl/mem_bank_sequencer.sv | 110 +++++++++++
 tb/tb_mem_bank_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and address-decode helpers for the banked data memory front-end.
package mem_pkg;

  localparam int WIDTH   = 32;
  localparam int RAMSIZE = 512;
  localparam int NBANKS  = 7;
  localparam int OB      = $clog2(RAMSIZE);

  // One buffered request as it travels through the request FIFO.
  typedef struct packed {
    logic             we;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
  } mem_req_t;

  // Upper address bits select the bank; values >= NBANKS are out of range.
  function automatic logic [WIDTH-OB-1:0] bank_of(input logic [WIDTH-1:0] addr);
    return addr[WIDTH-1:OB];
  endfunction

  // Lower address bits select the word inside a bank.
  function automatic logic [OB-1:0] offset_of(input logic [WIDTH-1:0] addr);
    return addr[OB-1:0];
  endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// In-order request buffer; power-of-two depth so pointers wrap naturally.
module mem_req_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  T            push_data,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count,
  output T            head
);

  T              store_q [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Entry storage carries no reset; only the bookkeeping below is cleared.
  always_ff @(posedge clk) begin
    if (push) store_q[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = store_q[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/mem_bank_sequencer.sv
// Request front-end for the banked data memory: buffers load/store requests,
// drives one bank per issue cycle and registers the response.
module mem_bank_sequencer
  import mem_pkg::*;
#(
  parameter int WIDTH   = mem_pkg::WIDTH,
  parameter int RAMSIZE = mem_pkg::RAMSIZE,
  parameter int NBANKS  = mem_pkg::NBANKS,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [WIDTH-1:0]         req_addr,
  input  logic [WIDTH-1:0]         req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_rdata,
  output logic                     rsp_err,
  output logic [15:0]              err_count,
  output logic [NBANKS-1:0]        mem_we,
  output logic [WIDTH*NBANKS-1:0]  mem_a,
  output logic [WIDTH*NBANKS-1:0]  mem_wd,
  input  logic [WIDTH*NBANKS-1:0]  mem_rd
);

  localparam int AW    = $clog2(DEPTH);
  localparam int OFS_W = $clog2(RAMSIZE);
  localparam int BW    = WIDTH - OFS_W;

  mem_req_t         req_in;
  mem_req_t         head;
  logic             full;
  logic             empty;
  logic [AW:0]      count;
  logic             push;
  logic             issue;
  logic [BW-1:0]    bank;
  logic [OFS_W-1:0] offset;
  logic             err;
  logic [WIDTH-1:0] rd_sel;
  logic [15:0]      err_cnt;

  assign req_in    = '{we: req_we, addr: req_addr, wdata: req_wdata};
  assign req_ready = rst_n && !full;
  assign push      = req_valid && req_ready;
  assign issue     = !empty && (!rsp_valid || rsp_ready);
  assign err_count = err_cnt;

  mem_req_fifo #(
    .DEPTH (DEPTH),
    .T     (mem_req_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (issue),
    .push_data (req_in),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head      (head)
  );

  // Decode the head entry and steer it onto exactly one bank while issuing.
  always_comb begin
    bank   = bank_of(head.addr);
    offset = offset_of(head.addr);
    err    = (bank >= BW'(NBANKS));
    mem_we = '0;
    mem_a  = '0;
    mem_wd = '0;
    rd_sel = '0;
    for (int k = 0; k < NBANKS; k++) begin
      if (!err && bank == BW'(k)) begin
        rd_sel = mem_rd[k*WIDTH +: WIDTH];
        if (issue) begin
          mem_we[k]                = head.we;
          mem_a[k*WIDTH +: WIDTH]  = WIDTH'(offset);
          mem_wd[k*WIDTH +: WIDTH] = head.wdata;
        end
      end
    end
  end

  // Response register and error counter; capture on issue, drop when consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      err_cnt   <= '0;
    end else if (issue) begin
      rsp_valid <= 1'b1;
      rsp_err   <= err;
      rsp_rdata <= (!head.we && !err) ? rd_sel : '0;
      if (err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Occupancy flags from the FIFO must agree with its count.
  always @(posedge clk) begin
    if (rst_n) assert (full == (count == (AW+1)'(DEPTH)));
  end

endmodule

// File: tb/tb_mem_bank_sequencer.sv
// Directed bench for mem_bank_sequencer with a banked memory model attached.
module tb_mem_bank_sequencer;

  localparam int W  = 32;
  localparam int NB = 7;
  localparam int RS = 512;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_we = 1'b0;
  logic [W-1:0]    req_addr = '0;
  logic [W-1:0]    req_wdata = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [W-1:0]    rsp_rdata;
  logic            rsp_err;
  logic [15:0]     err_count;
  logic [NB-1:0]   mem_we;
  logic [W*NB-1:0] mem_a;
  logic [W*NB-1:0] mem_wd;
  logic [W*NB-1:0] mem_rd;

  logic [W-1:0]    mem [NB][RS];
  logic            loaded = 1'b0;
  int              nvec = 0;
  int              nerr = 0;

  always #5 clk = ~clk;

  mem_bank_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .err_count (err_count),
    .mem_we    (mem_we),
    .mem_a     (mem_a),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd)
  );

  function automatic logic [W-1:0] img(input int k, input int i);
    return 32'hA000_0000 | (32'(k) << 16) | 32'(i);
  endfunction

  // Combinational read port per bank.
  always_comb begin
    for (int k = 0; k < NB; k++) mem_rd[k*W +: W] = mem[k][mem_a[k*W +: 9]];
  end

  // Preload the image once, then apply per-bank writes at the clock edge.
  always @(posedge clk) begin
    if (!loaded) begin
      for (int k = 0; k < NB; k++)
        for (int i = 0; i < RS; i++) mem[k][i] <= img(k, i);
      loaded <= 1'b1;
    end else begin
      for (int k = 0; k < NB; k++)
        if (mem_we[k]) mem[k][mem_a[k*W +: 9]] <= mem_wd[k*W +: W];
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic we, input logic [W-1:0] a, input logic [W-1:0] d);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic test_reset();
    tick();
    tick();
    nvec++; if (req_ready !== 1'b0) begin nerr++; $display("FAIL rst_req_ready: got %0b want 0", req_ready); end
    nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL rst_rsp_valid: got %0b want 0", rsp_valid); end
    nvec++; if (rsp_rdata !== 32'h0) begin nerr++; $display("FAIL rst_rsp_rdata: got %h want 0", rsp_rdata); end
    nvec++; if (rsp_err !== 1'b0) begin nerr++; $display("FAIL rst_rsp_err: got %0b want 0", rsp_err); end
    nvec++; if (err_count !== 16'h0) begin nerr++; $display("FAIL rst_err_count: got %h want 0", err_count); end
    nvec++; if (mem_we !== 7'h0) begin nerr++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    nvec++; if (mem_a !== '0 || mem_wd !== '0) begin nerr++; $display("FAIL rst_mem_a_wd: got a=%h wd=%h want 0", mem_a, mem_wd); end
    rst_n = 1'b1;
    #1;
    nvec++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL rst_release_ready: got %0b want 1", req_ready); end
    tick();
  endtask

  task automatic test_store_load();
    drive(1'b1, 1'b1, 32'h205, 32'hDEADBEEF);
    tick();
    nvec++; if (mem_we !== 7'b0000010) begin nerr++; $display("FAIL sl_mem_we: got %b want 0000010", mem_we); end
    nvec++; if (mem_a[63:32] !== 32'd5) begin nerr++; $display("FAIL sl_mem_a1: got %h want 5", mem_a[63:32]); end
    nvec++; if (mem_wd[63:32] !== 32'hDEADBEEF) begin nerr++; $display("FAIL sl_mem_wd1: got %h want deadbeef", mem_wd[63:32]); end
    nvec++; if (mem_a[31:0] !== 32'd0 || mem_wd[31:0] !== 32'd0) begin nerr++; $display("FAIL sl_other_slice: got a0=%h wd0=%h want 0", mem_a[31:0], mem_wd[31:0]); end
    drive(1'b1, 1'b0, 32'h205, 32'h0);
    tick();
    nvec++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin nerr++; $display("FAIL sl_store_rsp: got v=%0b e=%0b d=%h want 1 0 0", rsp_valid, rsp_err, rsp_rdata); end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    nvec++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF) begin nerr++; $display("FAIL sl_load_rsp: got v=%0b d=%h want 1 deadbeef", rsp_valid, rsp_rdata); end
    tick();
    nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL sl_idle: got %0b want 0", rsp_valid); end
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 1'b0, 32'hE00, 32'h0);
    tick();
    nvec++; if (mem_we !== 7'h0 || mem_a !== '0) begin nerr++; $display("FAIL oor_issue1: got we=%b a=%h want 0", mem_we, mem_a); end
    drive(1'b1, 1'b1, 32'hE01, 32'h1234);
    tick();
    nvec++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin nerr++; $display("FAIL oor_rsp1: got v=%0b e=%0b d=%h want 1 1 0", rsp_valid, rsp_err, rsp_rdata); end
    nvec++; if (mem_we !== 7'h0 || mem_a !== '0) begin nerr++; $display("FAIL oor_issue2: got we=%b a=%h want 0", mem_we, mem_a); end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    nvec++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin nerr++; $display("FAIL oor_rsp2: got v=%0b e=%0b d=%h want 1 1 0", rsp_valid, rsp_err, rsp_rdata); end
    nvec++; if (err_count !== 16'd2) begin nerr++; $display("FAIL oor_err_count: got %0d want 2", err_count); end
    tick();
    nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL oor_idle: got %0b want 0", rsp_valid); end
  endtask

  task automatic test_back_pressure();
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 32'(i), 32'h0);
      nvec++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL bp_accept%0d: got ready=%0b want 1", i, req_ready); end
      tick();
    end
    drive(1'b1, 1'b0, 32'd5, 32'h0);
    nvec++; if (req_ready !== 1'b0) begin nerr++; $display("FAIL bp_full: got ready=%0b want 0", req_ready); end
    nvec++; if (rsp_valid !== 1'b1 || rsp_rdata !== img(0, 0)) begin nerr++; $display("FAIL bp_first_held: got v=%0b d=%h want 1 %h", rsp_valid, rsp_rdata, img(0, 0)); end
    tick();
    nvec++; if (req_ready !== 1'b0 || rsp_rdata !== img(0, 0)) begin nerr++; $display("FAIL bp_stall: got ready=%0b d=%h want 0 %h", req_ready, rsp_rdata, img(0, 0)); end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      nvec++; if (rsp_valid !== 1'b1 || rsp_rdata !== img(0, i)) begin nerr++; $display("FAIL bp_drain%0d: got v=%0b d=%h want 1 %h", i, rsp_valid, rsp_rdata, img(0, i)); end
      tick();
    end
    nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL bp_done: got %0b want 0", rsp_valid); end
  endtask

  task automatic test_streaming();
    logic [W-1:0] addrs [8];
    logic [W-1:0] expd  [8];
    for (int k = 0; k < 7; k++) begin
      addrs[k] = 32'(k * 32'h200);
      expd[k]  = img(k, 0);
    end
    addrs[7] = 32'h001;
    expd[7]  = img(0, 1);
    rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c >= 2) begin
        nvec++; if (rsp_valid !== 1'b1 || rsp_rdata !== expd[c-2]) begin nerr++; $display("FAIL st_rsp%0d: got v=%0b d=%h want 1 %h", c - 2, rsp_valid, rsp_rdata, expd[c-2]); end
      end
      if (c >= 1 && c <= 8) begin
        nvec++; if (mem_we !== 7'h0) begin nerr++; $display("FAIL st_we%0d: got %b want 0", c, mem_we); end
      end
      if (c < 8) drive(1'b1, 1'b0, addrs[c], 32'h0);
      else       drive(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
    end
    nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL st_idle: got %0b want 0", rsp_valid); end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    drive(1'b1, 1'b0, 32'h010, 32'h0);
    tick();
    drive(1'b1, 1'b1, 32'h410, 32'h5555_0000);
    tick();
    drive(1'b1, 1'b1, 32'h411, 32'h5555_0001);
    tick();
    drive(1'b1, 1'b1, 32'h412, 32'h5555_0002);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    nvec++; if (rsp_valid !== 1'b1 || req_ready !== 1'b1) begin nerr++; $display("FAIL rm_pre: got v=%0b ready=%0b want 1 1", rsp_valid, req_ready); end
    rst_n = 1'b0;
    #1;
    nvec++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || req_ready !== 1'b0) begin nerr++; $display("FAIL rm_async: got v=%0b d=%h ready=%0b want 0 0 0", rsp_valid, rsp_rdata, req_ready); end
    nvec++; if (err_count !== 16'h0 || mem_we !== 7'h0 || mem_a !== '0 || mem_wd !== '0) begin nerr++; $display("FAIL rm_async_mem: got ec=%h we=%b want 0 0", err_count, mem_we); end
    #2;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    tick();
    for (int c = 0; c < 3; c++) begin
      nvec++; if (rsp_valid !== 1'b0 || mem_we !== 7'h0 || req_ready !== 1'b1) begin nerr++; $display("FAIL rm_after%0d: got v=%0b we=%b ready=%0b want 0 0 1", c, rsp_valid, mem_we, req_ready); end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      nvec++; if (mem[2][16+i] !== img(2, 16 + i)) begin nerr++; $display("FAIL rm_nowrite%0d: got %h want %h", i, mem[2][16+i], img(2, 16 + i)); end
    end
  endtask

  task automatic test_saturation();
    rsp_ready = 1'b1;
    force dut.err_cnt = 16'hFFFE;
    tick();
    release dut.err_cnt;
    drive(1'b1, 1'b0, 32'hE00, 32'h0);
    tick();
    drive(1'b1, 1'b1, 32'hE01, 32'h77);
    tick();
    nvec++; if (err_count !== 16'hFFFF || rsp_err !== 1'b1) begin nerr++; $display("FAIL sat_1: got ec=%h e=%0b want ffff 1", err_count, rsp_err); end
    drive(1'b1, 1'b0, 32'hF02, 32'h0);
    tick();
    nvec++; if (err_count !== 16'hFFFF || rsp_err !== 1'b1) begin nerr++; $display("FAIL sat_2: got ec=%h e=%0b want ffff 1", err_count, rsp_err); end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    nvec++; if (err_count !== 16'hFFFF || rsp_err !== 1'b1 || rsp_valid !== 1'b1) begin nerr++; $display("FAIL sat_3: got ec=%h e=%0b v=%0b want ffff 1 1", err_count, rsp_err, rsp_valid); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    test_reset();
    test_store_load();
    test_out_of_range();
    test_back_pressure();
    test_streaming();
    test_reset_mid();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
